ntr_cmd_decoder: RTL
====================

# ntr_cmd_decoder

Clock-domain consumer for the NTR bus receiver. It takes the 64-bit command word and `ready` flag produced in the cartridge-clock domain and synchronises `ready` into `clk`. On each new command it captures the word exactly once and decodes the opcode byte. It updates a 4-bit LED register and reports per-command strobes and counters. It replaces the ad-hoc LED state machine in the top level.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `ntr_ready`. Legal values are 2 to 4.
- `LED_RESET`, default 4'b0000: value loaded into the LED register on reset.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ntr_ready`  in  1  command-complete flag from the NTR receiver. It is asynchronous to `clk`.
- `ntr_command`  in  64  command word. It is stable while `ntr_ready` is high. The opcode is `[7:0]`; argument bits are `[63:8]`.
- `leds`  out  4  LED register.
- `cmd_valid`  out  1  one-cycle strobe, asserted once per decoded command.
- `cmd_opcode`  out  8  opcode of the last decoded command.
- `cmd_count`  out  8  number of decoded commands. Wraps modulo 256.
- `bad_cmd`  out  1  sticky flag: an unknown opcode has been seen.
- `busy`  out  1  high in CAPTURE, DECODE and WAIT_RELEASE.

## Operation
- **Synchroniser:** `ntr_ready` passes through `SYNC_STAGES` flops; the last stage is `rdy_s`. No other input is synchronised. `ntr_command` is sampled only after `rdy_s` is seen high, when it is quasi-static.
- **FSM states and transitions:**
  - IDLE → CAPTURE when `rdy_s`=1.
  - CAPTURE:
    - If `rdy_s`=1, latch `ntr_command` into `cmd_reg` and go to DECODE.
    - If `rdy_s`=0 (glitch or aborted transfer), return to IDLE. Nothing is latched or counted.
  - DECODE: apply the opcode, pulse `cmd_valid`, then go to WAIT_RELEASE unconditionally.
  - WAIT_RELEASE → IDLE when `rdy_s`=0. It stays in WAIT_RELEASE while `rdy_s`=1, so a `ready` level held high is decoded exactly once.
- **Opcodes** (all executed in DECODE):
  - 0xFF: `leds[3]` ← `cmd_reg[56]`; `leds[2:0]` unchanged.
  - 0xF0: `leds` ← `cmd_reg[59:56]`.
  - 0xF1: `leds` ← `leds ^ cmd_reg[59:56]`.
  - 0x00: no-op. `leds` is unchanged.
  - Any other value: `leds` unchanged and `bad_cmd` ← 1.
- For every decoded opcode, including unknown ones:
  - `cmd_opcode` ← `cmd_reg[7:0]`.
  - `cmd_count` ← `cmd_count + 1`, wrapping from 255 to 0.
  - `cmd_valid` = 1 for that single cycle.
- `bad_cmd` clears only on reset.

## Timing
- **Reset values:**
  - `leds` = `LED_RESET`.
  - `cmd_valid` = 0, `cmd_opcode` = 0x00, `cmd_count` = 0, `bad_cmd` = 0, `busy` = 0.
  - FSM in IDLE; synchroniser flops cleared.
- Reset asserted mid-command aborts immediately. After release, a still-high `ntr_ready` is treated as a new command once it propagates through the synchroniser.
- **Latency**, with `ntr_ready` rising just before clock edge E0 and `SYNC_STAGES`=2:
  - `rdy_s`=1 after E1.
  - FSM enters CAPTURE at E2.
  - `cmd_reg` latched at E3 (enters DECODE).
  - `leds`, `cmd_opcode`, `cmd_count` and `bad_cmd` update, and `cmd_valid` rises, at E4. `cmd_valid` falls at E5.
  - Each extra synchroniser stage adds one cycle.
- **Release:** `ntr_ready` must stay low for at least `SYNC_STAGES` clocks to be recognised.
- **Throughput:** at most one command per `SYNC_STAGES + 3` clocks.
- All outputs are registered; there are no combinational paths from input to output.
- `ntr_command` changing while `rdy_s`=1 after the CAPTURE edge has no effect.

## Test plan
- **Reset:** assert `rst` with `LED_RESET`=4'b1010.
  - Expect `leds`=1010, `cmd_count`=0, `bad_cmd`=0 and `busy`=0 asynchronously, with no clock edge needed.
- **Set LED bit:** `ntr_command`=0x0100_0000_0000_00FF, raise `ntr_ready`.
  - Expect `cmd_valid` one cycle at E4, `leds`=1000 (from 0000), `cmd_opcode`=0xFF, `cmd_count`=1.
- **Load then toggle:**
  - Opcode 0xF0 with `[59:56]`=0110 gives `leds`=0110.
  - Then opcode 0xF1 with 0011 gives `leds`=0101 and `cmd_count`=2.
- **Held ready:** keep `ntr_ready` high for 50 clocks with one command.
  - Expect exactly one `cmd_valid`.
  - Drop `ntr_ready` for 3 clocks and raise it again: expect a second `cmd_valid`.
- **Glitch and unknown opcode:**
  - A one-clock `ntr_ready` pulse aligned so that `rdy_s` falls in CAPTURE: no `cmd_valid`, count unchanged.
  - Opcode 0x42: `bad_cmd`=1 and stays 1 after a following valid 0x00.
- **Wrap and reset mid-command:**
  - 256 commands take `cmd_count` back to 0.
  - Assert `rst` while in DECODE: all outputs return to reset values. After release, a still-high `ntr_ready` decodes once.

Source files
------------

// File: rtl/ntr_cmd_decoder.sv
// ntr_cmd_decoder: synchronises the NTR ready flag into clk, captures
// each command word once, and decodes its opcode into LEDs and counters.
module ntr_cmd_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [3:0]  LED_RESET   = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ntr_ready,
    input  logic [63:0] ntr_command,
    output logic [3:0]  leds,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [7:0]  cmd_count,
    output logic        bad_cmd,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DECODE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_s;

    // Only the opcode and the LED argument nibble matter to the decoder.
    logic [11:0] cmd_q, cmd_d;
    logic [3:0]  leds_q, leds_d;
    logic        valid_q, valid_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  count_q, count_d;
    logic        bad_q, bad_d;
    logic        busy_q, busy_d;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{ntr_command[63:60], ntr_command[55:8]};

    assign rdy_s = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser on the asynchronous ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ntr_ready};
        end
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            leds_q   <= LED_RESET;
            valid_q  <= 1'b0;
            opcode_q <= 8'h00;
            count_q  <= 8'h00;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            leds_q   <= leds_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
            bad_q    <= bad_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic and opcode execution.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        leds_d   = leds_q;
        valid_d  = 1'b0;
        opcode_d = opcode_q;
        count_d  = count_q;
        bad_d    = bad_q;
        unique case (state_q)
            S_IDLE: begin
                if (rdy_s) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (rdy_s) begin
                    cmd_d   = {ntr_command[59:56], ntr_command[7:0]};
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                opcode_d = cmd_q[7:0];
                count_d  = count_q + 8'd1;
                valid_d  = 1'b1;
                state_d  = S_WAIT;
                case (cmd_q[7:0])
                    8'hFF:   leds_d[3] = cmd_q[8];
                    8'hF0:   leds_d = cmd_q[11:8];
                    8'hF1:   leds_d = leds_q ^ cmd_q[11:8];
                    8'h00:   leds_d = leds_q;
                    default: bad_d = 1'b1;
                endcase
            end
            S_WAIT: begin
                if (!rdy_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign leds       = leds_q;
    assign cmd_valid  = valid_q;
    assign cmd_opcode = opcode_q;
    assign cmd_count  = count_q;
    assign bad_cmd    = bad_q;
    assign busy       = busy_q;

endmodule
